// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the two picorv32-style master ports (m0 = CPU, m1 = DMA), the
//   shared slave port and the arbiter status outputs into one interface.
//
//   Handshake (all ports): a requester raises *_valid with addr/wdata/wstrb
//   stable and holds them until the responder pulses *_ready for exactly one
//   cycle; *_rdata is only meaningful in that cycle. wstrb == 0 means read.
//
//   Modports:
//     master : the arbiter's view (it drives the slave bus and the master
//              responses).
//     slave  : the surrounding system's view (masters and slave decoder).
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        grant;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata,
    output grant, busy, timeout_err
  );

  modport slave (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata,
    input  grant, busy, timeout_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master round-robin arbiter for the picorv32 native memory bus.
//   One transaction per grant; a watchdog force-completes transactions the
//   slave never acknowledges.
//
// Ports:
//   clk_cpu  : clock, rising edge
//   n_reset  : asynchronous active-low reset
//   bus      : mem_bus_arbiter_if.master -- m0_*/m1_* master ports, s_*
//              slave port, grant/busy/timeout_err status
//
// The FSM state is directly observable: busy == (state_q == BUSY), and
// grant reflects grant_q.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic               clk_cpu,
  input  logic               n_reset,
  mem_bus_arbiter_if.master  bus
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit            WD_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic          in_busy;
  logic          g_valid;
  logic          done;
  logic          fire;
  logic          abort;
  logic          pick;
  logic [31:0]   resp_data;

  // Transaction status, decoded from registered state plus live inputs.
  always_comb begin
    in_busy = (state_q == BUSY);
    g_valid = grant_q ? bus.m1_valid : bus.m0_valid;
    done    = in_busy && bus.s_ready;
    // s_ready has priority over the watchdog in the same cycle.
    fire    = WD_EN && in_busy && g_valid && !bus.s_ready && (cnt_q == TO_LAST);
    abort   = in_busy && !g_valid && !bus.s_ready;
    // Tie goes to the master that did not win last time.
    if (bus.m0_valid && bus.m1_valid) pick = ~last_q;
    else                              pick = bus.m1_valid;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.m0_valid || bus.m1_valid) begin
          state_d = BUSY;
          grant_d = pick;
          last_d  = pick;
        end
      end
      BUSY: begin
        if (done || fire || abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slave-side mux and master responses are combinational so completion
  // reaches the master in the same cycle the slave acknowledges.
  always_comb begin
    resp_data       = fire ? TIMEOUT_RDATA : bus.s_rdata;
    bus.s_valid     = in_busy && g_valid && !fire;
    bus.s_addr      = '0;
    bus.s_wdata     = '0;
    bus.s_wstrb     = '0;
    if (in_busy) begin
      bus.s_addr  = grant_q ? bus.m1_addr  : bus.m0_addr;
      bus.s_wdata = grant_q ? bus.m1_wdata : bus.m0_wdata;
      bus.s_wstrb = grant_q ? bus.m1_wstrb : bus.m0_wstrb;
    end
    bus.m0_ready    = (done || fire) && !grant_q;
    bus.m1_ready    = (done || fire) &&  grant_q;
    bus.m0_rdata    = bus.m0_ready ? resp_data : 32'h0;
    bus.m1_rdata    = bus.m1_ready ? resp_data : 32'h0;
    bus.grant       = grant_q;
    bus.busy        = in_busy;
    bus.timeout_err = fire;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (TIMEOUT_CYCLES = 8). Inputs change on
//   the falling edge; outputs are checked 1 time unit later, away from the
//   rising edge where state updates.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic clk;
  logic n_reset;
  int   n_checks;
  int   n_fail;
  logic [0:0] exp_q[$];

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk_cpu (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_valid = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
    bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
    bus.s_ready  = 0; bus.s_rdata = 0;
  endtask

  task automatic apply_reset();
    step();
    clear_inputs();
    n_reset = 0;
    step();
    step();
    n_reset = 1;
  endtask

  task automatic test_reset();
    step();
    clear_inputs();
    n_reset = 0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b want 0", bus.s_valid); end
    n_checks++; if (bus.grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
    n_checks++; if ({bus.m0_ready, bus.m1_ready, bus.timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_ready_err: got %b want 000", {bus.m0_ready, bus.m1_ready, bus.timeout_err}); end
    step();
    n_reset = 1;
  endtask

  // m0 read, slave acks in the second busy cycle
  task automatic test_read();
    apply_reset();
    bus.m0_valid = 1; bus.m0_addr = 32'h0100_0010; bus.m0_wstrb = 4'b0000;
    #1;
    n_checks++; if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL read_idle_s_valid: got %b want 0", bus.s_valid); end
    step(); #1;
    n_checks++; if (bus.s_valid !== 1'b1) begin n_fail++; $display("FAIL read_s_valid: got %b want 1", bus.s_valid); end
    n_checks++; if (bus.s_addr !== 32'h0100_0010) begin n_fail++; $display("FAIL read_s_addr: got %h want 01000010", bus.s_addr); end
    n_checks++; if (bus.m0_ready !== 1'b0) begin n_fail++; $display("FAIL read_early_ready: got %b want 0", bus.m0_ready); end
    step();
    bus.s_ready = 1; bus.s_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (bus.m0_ready !== 1'b1) begin n_fail++; $display("FAIL read_m0_ready: got %b want 1", bus.m0_ready); end
    n_checks++; if (bus.m0_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL read_m0_rdata: got %h want 12345678", bus.m0_rdata); end
    n_checks++; if (bus.m1_ready !== 1'b0) begin n_fail++; $display("FAIL read_m1_ready: got %b want 0", bus.m1_ready); end
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL read_timeout_err: got %b want 0", bus.timeout_err); end
    step();
    bus.s_ready = 0; bus.m0_valid = 0;
    #1;
    n_checks++; if ({bus.busy, bus.m0_ready} !== 2'b00) begin n_fail++; $display("FAIL read_back_idle: got %b want 00", {bus.busy, bus.m0_ready}); end
  endtask

  // both masters hold requests; grants must alternate 0,1,0,1
  task automatic test_back_to_back();
    int r0, r1;
    logic [0:0] exp_g;
    apply_reset();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    r0 = 0; r1 = 0;
    bus.m0_valid = 1; bus.m0_addr = 32'h0000_1000;
    bus.m1_valid = 1; bus.m1_addr = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 6; w++) begin
        step();
        bus.s_ready = 0;
        #1;
        r0 += int'(bus.m0_ready); r1 += int'(bus.m1_ready);
        if (bus.busy === 1'b1) break;
      end
      exp_g = exp_q.pop_front();
      n_checks++; if (bus.busy !== 1'b1 || bus.grant !== exp_g[0]) begin n_fail++; $display("FAIL b2b_grant%0d: got busy=%b grant=%b want busy=1 grant=%b", t, bus.busy, bus.grant, exp_g[0]); end
      n_checks++; if (bus.s_addr !== (exp_g[0] ? 32'h0000_2000 : 32'h0000_1000)) begin n_fail++; $display("FAIL b2b_addr%0d: got %h", t, bus.s_addr); end
      bus.s_ready = 1; bus.s_rdata = 32'hA000_0000 + 32'(t);
      #1;
      r0 += int'(bus.m0_ready); r1 += int'(bus.m1_ready);
    end
    step();
    clear_inputs();
    n_checks++; if (r0 !== 2) begin n_fail++; $display("FAIL b2b_m0_ready_count: got %0d want 2", r0); end
    n_checks++; if (r1 !== 2) begin n_fail++; $display("FAIL b2b_m1_ready_count: got %0d want 2", r1); end
  endtask

  // m1 byte write while m0 idle
  task automatic test_m1_write();
    apply_reset();
    bus.m1_valid = 1; bus.m1_addr = 32'hFE00_0000; bus.m1_wdata = 32'h0000_002A; bus.m1_wstrb = 4'b0001;
    #1;
    n_checks++; if ({bus.s_wstrb, bus.s_addr} !== 36'h0) begin n_fail++; $display("FAIL wr_idle_mux: got %h want 0", {bus.s_wstrb, bus.s_addr}); end
    step(); #1;
    n_checks++; if (bus.grant !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got %b want 1", bus.grant); end
    n_checks++; if (bus.s_wstrb !== 4'b0001) begin n_fail++; $display("FAIL wr_s_wstrb: got %b want 0001", bus.s_wstrb); end
    n_checks++; if (bus.s_wdata !== 32'h0000_002A) begin n_fail++; $display("FAIL wr_s_wdata: got %h want 0000002a", bus.s_wdata); end
    n_checks++; if (bus.s_addr !== 32'hFE00_0000) begin n_fail++; $display("FAIL wr_s_addr: got %h want fe000000", bus.s_addr); end
    n_checks++; if (bus.m1_ready !== 1'b0) begin n_fail++; $display("FAIL wr_early_ready: got %b want 0", bus.m1_ready); end
    step();
    bus.s_ready = 1; bus.s_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if ({bus.m1_ready, bus.m0_ready} !== 2'b10) begin n_fail++; $display("FAIL wr_ready: got %b want 10", {bus.m1_ready, bus.m0_ready}); end
    n_checks++; if (bus.m0_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_ungranted_rdata: got %h want 0", bus.m0_rdata); end
    step();
    clear_inputs();
  endtask

  // slave never acks: watchdog fires in the 8th busy cycle
  task automatic test_timeout();
    apply_reset();
    bus.m0_valid = 1; bus.m0_addr = 32'h0300_0000;
    for (int c = 1; c <= 7; c++) begin
      step(); #1;
      n_checks++; if ({bus.busy, bus.s_valid, bus.m0_ready, bus.timeout_err} !== 4'b1100) begin n_fail++; $display("FAIL to_wait%0d: got %b want 1100", c, {bus.busy, bus.s_valid, bus.m0_ready, bus.timeout_err}); end
    end
    step(); #1;
    n_checks++; if ({bus.m0_ready, bus.timeout_err, bus.s_valid} !== 3'b110) begin n_fail++; $display("FAIL to_fire: got %b want 110", {bus.m0_ready, bus.timeout_err, bus.s_valid}); end
    n_checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_rdata: got %h want deadbeef", bus.m0_rdata); end
    step();
    bus.m0_valid = 0;
    bus.m1_valid = 1; bus.m1_addr = 32'h0400_0000;
    bus.s_ready = 1; bus.s_rdata = 32'h0BAD_0ACC;
    #1;
    n_checks++; if ({bus.busy, bus.m0_ready, bus.m1_ready, bus.timeout_err} !== 4'b0000) begin n_fail++; $display("FAIL to_late_ack_idle: got %b want 0000", {bus.busy, bus.m0_ready, bus.m1_ready, bus.timeout_err}); end
    step();
    bus.s_rdata = 32'h0000_0077;
    #1;
    n_checks++; if ({bus.grant, bus.m1_ready, bus.timeout_err} !== 3'b110) begin n_fail++; $display("FAIL to_next_grant: got %b want 110", {bus.grant, bus.m1_ready, bus.timeout_err}); end
    n_checks++; if (bus.m1_rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL to_next_rdata: got %h want 00000077", bus.m1_rdata); end
    step();
    clear_inputs();
  endtask

  // s_ready in the 8th busy cycle beats the watchdog
  task automatic test_timeout_race();
    apply_reset();
    bus.m0_valid = 1; bus.m0_addr = 32'h0500_0000;
    for (int c = 1; c <= 7; c++) step();
    step();
    bus.s_ready = 1; bus.s_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if ({bus.m0_ready, bus.timeout_err, bus.s_valid} !== 3'b101) begin n_fail++; $display("FAIL race_flags: got %b want 101", {bus.m0_ready, bus.timeout_err, bus.s_valid}); end
    n_checks++; if (bus.m0_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL race_rdata: got %h want cafef00d", bus.m0_rdata); end
    step();
    clear_inputs();
  endtask

  // master drops valid mid-transaction: back to idle with no response
  task automatic test_abort();
    apply_reset();
    bus.m1_valid = 1; bus.m1_addr = 32'h0600_0000;
    step(); step();
    bus.m1_valid = 0;
    #1;
    n_checks++; if ({bus.s_valid, bus.m1_ready, bus.timeout_err} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b want 000", {bus.s_valid, bus.m1_ready, bus.timeout_err}); end
    step(); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", bus.busy); end
  endtask

  // reset asserted while busy, then a tie after release must go to m0
  task automatic test_reset_mid_busy();
    apply_reset();
    bus.m1_valid = 1; bus.m1_addr = 32'h0700_0000;
    step(); #1;
    n_checks++; if ({bus.busy, bus.grant} !== 2'b11) begin n_fail++; $display("FAIL rmb_pre: got %b want 11", {bus.busy, bus.grant}); end
    #1;
    n_reset = 0;
    bus.s_ready = 1;
    #1;
    n_checks++; if ({bus.busy, bus.grant, bus.s_valid, bus.m0_ready, bus.m1_ready, bus.timeout_err} !== 6'b0) begin n_fail++; $display("FAIL rmb_outputs: got %b want 000000", {bus.busy, bus.grant, bus.s_valid, bus.m0_ready, bus.m1_ready, bus.timeout_err}); end
    n_checks++; if (bus.s_addr !== 32'h0) begin n_fail++; $display("FAIL rmb_s_addr: got %h want 0", bus.s_addr); end
    step();
    n_reset = 1;
    bus.s_ready = 0;
    bus.m0_valid = 1; bus.m0_addr = 32'h0800_0000;
    step(); #1;
    n_checks++; if ({bus.busy, bus.grant} !== 2'b10) begin n_fail++; $display("FAIL rmb_tie_m0: got %b want 10", {bus.busy, bus.grant}); end
    step();
    clear_inputs();
  endtask

  // scoreboard report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_reset  = 0;
    clear_inputs();
    test_reset();
    test_read();
    test_back_to_back();
    test_m1_write();
    test_timeout();
    test_timeout_race();
    test_abort();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
